// File: rtl/alu_serial_seq_if.sv
// Start/done handshake bundle between the multi-cycle core and the bit-serial ALU sequencer.
// The core drives operands and op; the sequencer returns status and the registered result.
interface alu_serial_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, op,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: evaluates AND/OR/ADD/SUB/SLT one bit per clock, LSB first, through a
// 1-bit slice with a carry register; SLT takes one extra FIX cycle for the sign correction.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic                 i_clk,
  input logic                 i_rst,
  alu_serial_seq_if.slave     bus
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [IdxW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;

  logic w_bi;
  logic w_sum;
  logic w_carry_nxt;
  logic w_arith;
  logic w_bit;
  logic w_last;

  // 1-bit slice: operands are shifted right each bit so bit 0 is always the active bit
  always_comb begin
    w_bi        = r_op[2] ? ~r_b[0] : r_b[0];
    w_sum       = r_a[0] ^ w_bi ^ r_carry;
    w_carry_nxt = (r_a[0] & w_bi) | (r_a[0] & r_carry) | (w_bi & r_carry);
    w_arith     = (r_op == 3'b010) || (r_op == 3'b110) || (r_op == 3'b111);
    w_last      = (r_idx == LastIdx);
    case (r_op)
      3'b000:                 w_bit = r_a[0] & w_bi;
      3'b001:                 w_bit = r_a[0] | w_bi;
      3'b010, 3'b110, 3'b111: w_bit = w_sum;
      default:                w_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (bus.start) w_state_nxt = StRun;
      StRun:   if (w_last) w_state_nxt = (r_op == 3'b111) ? StFix : StDone;
      StFix:   w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_op     <= bus.op;
            r_idx    <= '0;
            r_carry  <= bus.op[2];
            r_result <= '0;
          end
        end
        StRun: begin
          r_result <= {w_bit, r_result[WIDTH-1:1]};
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_idx    <= r_idx + IdxW'(1);
          if (w_arith) r_carry <= w_carry_nxt;
          if (w_last) begin
            // r_carry is the carry into the MSB here; SLT keeps the raw overflow for FIX
            r_cout     <= w_arith & w_carry_nxt;
            r_overflow <= w_arith & (r_carry ^ w_carry_nxt);
          end
        end
        StFix: begin
          r_result   <= WIDTH'(r_result[WIDTH-1] ^ r_overflow);
          r_overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != StIdle);
  assign bus.done     = (r_state == StDone);
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_overflow;
  assign bus.zero     = ~|r_result;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq: vector table for result/flags/latency, plus hand-written
// sequences for ignored starts and reset mid-operation.
module tb_alu_serial_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           cyc;
  } vec_t;

  vec_t vecs[11];

  int n_checks = 0;
  int n_errors = 0;

  int           g_cyc;
  bit           g_timeout;
  logic [W-1:0] g_res;
  logic [W-1:0] g_res_after;
  logic         g_cout, g_ovf, g_zero, g_busy1, g_busy_after;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse (bounded).
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.op    = op;
    @(posedge clk);
    g_cyc     = 0;
    g_timeout = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.op    = 3'b101;
        g_busy1   = bus.busy;
      end
      if (bus.done) begin
        g_cyc     = c;
        g_res     = bus.result;
        g_cout    = bus.cout;
        g_ovf     = bus.overflow;
        g_zero    = bus.zero;
        g_timeout = 1'b0;
        break;
      end
    end
    if (!g_timeout) begin
      @(negedge clk);
      g_busy_after = bus.busy;
      g_res_after  = bus.result;
    end
  endtask

  initial begin
    int           ndone;
    int           dcyc;
    logic [W-1:0] dres;

    vecs[0]  = '{"add_wrap",   3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 33};
    vecs[1]  = '{"sub_ovf",    3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 0, 33};
    vecs[2]  = '{"add_ovf",    3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 33};
    vecs[3]  = '{"slt_neg",    3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0, 0, 34};
    vecs[4]  = '{"slt_ovfcor", 3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 0, 0, 1, 34};
    vecs[5]  = '{"and",        3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 33};
    vecs[6]  = '{"or",         3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 33};
    vecs[7]  = '{"reserved",   3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0, 1, 33};
    vecs[8]  = '{"sub_zero",   3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 1, 33};
    vecs[9]  = '{"add_plain",  3'b010, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, 33};
    vecs[10] = '{"slt_pos",    3'b111, 32'h00000003, 32'h00000007, 32'h00000001, 0, 0, 0, 34};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      if (g_timeout) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_timeout: no done within 100 cycles", vecs[i].name);
      end else begin
        chk({vecs[i].name, "_result"}, 64'(g_res), 64'(vecs[i].res));
        chk({vecs[i].name, "_cout"}, 64'(g_cout), 64'(vecs[i].cout));
        chk({vecs[i].name, "_ovf"}, 64'(g_ovf), 64'(vecs[i].ovf));
        chk({vecs[i].name, "_zero"}, 64'(g_zero), 64'(vecs[i].zero));
        chk({vecs[i].name, "_cycle"}, 64'(g_cyc), 64'(vecs[i].cyc));
        chk({vecs[i].name, "_busy1"}, 64'(g_busy1), 64'd1);
        chk({vecs[i].name, "_busy_after"}, 64'(g_busy_after), 64'd0);
        chk({vecs[i].name, "_hold"}, 64'(g_res_after), 64'(vecs[i].res));
      end
    end

    // Starts with different operands mid-run must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd2;
    bus.op    = 3'b010;
    @(posedge clk);
    ndone = 0;
    dcyc  = 0;
    dres  = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == 5) || (c == 20);
      bus.a     = 32'd100;
      bus.b     = 32'd200;
      bus.op    = 3'b110;
      if (bus.done) begin
        ndone++;
        dcyc = c;
        dres = bus.result;
      end
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_cycle", 64'(dcyc), 64'd33);
    chk("ign_result", 64'(dres), 64'd3);

    // Reset in cycle 10 of an ADD aborts it with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h0000FFFF;
    bus.b     = 32'h00000001;
    bus.op    = 3'b010;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) ndone++;
      if (c == 10) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_zero", 64'(bus.zero), 64'd1);
    chk("abort_cout", 64'(bus.cout), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    do_op(3'b010, 32'h0000FFFF, 32'h00000001);
    if (g_timeout) begin
      n_checks++;
      n_errors++;
      $display("FAIL post_abort_timeout: no done within 100 cycles");
    end else begin
      chk("post_abort_result", 64'(g_res), 64'h00010000);
      chk("post_abort_cycle", 64'(g_cyc), 64'd33);
      chk("post_abort_zero", 64'(g_zero), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
